mips_mc_ctrl: RTL
=================

// Module: mips_mc_ctrl
// PURPOSE
//  Parametrised multi-cycle MIPS main controller: Moore FSM plus ALU decoder driving the 64-bit multi-cycle datapath.
//  Successor to the fixed controller: adds BNE, ADDI, J, a memory wait-state handshake (mem_ready), a wait timeout, and an illegal-instruction trap.
//  Sits between instr[31:26]/instr[5:0] plus datapath zero, and all datapath/memory control strobes.
// PARAMETERS
//  ALU_CTRL_W   3   width of alu_control
//  MEM_WAIT_EN  1   1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1
//  MAX_WAIT     15  wait cycles tolerated in a memory state before trapping (1..255)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-high
//  op           in   6   instr[31:26]
//  funct        in   6   instr[5:0]
//  zero         in   1   ALU zero flag
//  mem_ready    in   1   memory completes the access this cycle
//  pc_en        out  1   PC register enable (pc_write | taken branch)
//  iord         out  1   0: PC addresses memory, 1: ALUOut
//  mem_read     out  1   memory read request
//  mem_write    out  1   memory write request
//  ir_write     out  1   instruction register load
//  reg_dst      out  1   1: rd, 0: rt
//  mem_to_reg   out  1   1: data register, 0: ALUOut
//  reg_write    out  1   register file write
//  alu_src_a    out  1   0: PC, 1: A
//  alu_src_b    out  2   00 B, 01 const 4, 10 signimm, 11 signimm<<2
//  pc_src       out  2   00 ALU result, 01 ALUOut, 10 jump target
//  alu_control  out  ALU_CTRL_W  010 add, 110 sub, 000 and, 001 or, 111 slt
//  illegal      out  1   sticky: unsupported op/funct decoded
//  mem_timeout  out  1   sticky: wait exceeded MAX_WAIT
//  state_dbg    out  4   current state encoding
// BEHAVIOUR
//  Reset: state<=FETCH, wait_cnt<=0, illegal<=0, mem_timeout<=0; while reset=1 pc_en, ir_write, mem_write, reg_write, mem_read forced 0.
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, ALU_WB, BEQ_EX, BNE_EX, ADDI_EX, ADDI_WB, J_EX, TRAP.
//  FETCH: iord=0, mem_read=1, src_a=0, src_b=01, aluop add, pc_src=00; ir_write and pc_en only in the cycle mem_ready=1, then ->DECODE.
//  DECODE: src_a=0, src_b=11, add. op 000000->RTYPE_EX, 100011/101011->MEMADR, 000100->BEQ_EX, 000101->BNE_EX, 001000->ADDI_EX, 000010->J_EX, else illegal<=1, ->TRAP.
//  MEMADR: src_a=1, src_b=10, add; lw->MEMRD, sw->MEMWR.
//  MEMRD: iord=1, mem_read=1; ->MEMWB on mem_ready. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 ->FETCH.
//  MEMWR: iord=1, mem_write held 1 until mem_ready cycle inclusive; ->FETCH.
//  RTYPE_EX: src_a=1, src_b=00, alu_control from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); other funct -> illegal<=1, ->TRAP, no writeback.
//  ALU_WB: reg_dst=1, mem_to_reg=0, reg_write=1 ->FETCH.
//  BEQ_EX/BNE_EX: src_a=1, src_b=00, sub, pc_src=01; pc_en=zero (BEQ) / ~zero (BNE); ->FETCH.
//  ADDI_EX: src_a=1, src_b=10, add ->ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1 ->FETCH.
//  J_EX: pc_src=10, pc_en=1 ->FETCH.
//  Wait rule (FETCH/MEMRD/MEMWR): wait_cnt increments each cycle with mem_ready=0, clears on state exit; mem_ready=0 when wait_cnt==MAX_WAIT -> mem_timeout<=1, ->TRAP, request strobes drop next cycle.
//  TRAP: all strobes 0, absorbing until reset. Unlisted outputs 0 in each state.
//  Latency with mem_ready=1: lw 5, sw 4, R/addi 4, beq/bne/j 3 cycles.
//  Reset mid-instruction: next cycle is FETCH, no partial writeback/store completes.
// STRUCTURE
//  Package mips_mc_pkg: state enum (4-bit), opcode/funct localparams, ALU control codes, alu_src_b/pc_src encodings.
//  Sub-module mips_alu_dec: comb aluop(2)+funct -> alu_control, funct_illegal.
// TESTING
//  lw, mem_ready=1: states FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1 exactly cycle 5, pc_en exactly cycle 1.
//  beq zero=1 -> pc_en=1 in BEQ_EX; bne zero=1 -> pc_en=0; j -> pc_src=10, pc_en=1 in cycle 3.
//  sw with mem_ready low 3 cycles in MEMWR -> mem_write high 4 cycles, single FETCH after.
//  MAX_WAIT=15, mem_ready stuck 0 in FETCH -> mem_timeout=1 after 16 cycles, state_dbg=TRAP, pc_en never 1.
//  R-type funct 000111 -> illegal=1, TRAP, reg_write never asserted; op 111111 -> TRAP from DECODE.
//  reset asserted in MEMRD -> strobes 0 during reset, FETCH next, flags cleared.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller: state enum, opcode/funct
// values, ALU control codes and datapath mux selects.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StAluWb   = 4'd7,
        StBeqEx   = 4'd8,
        StBneEx   = 4'd9,
        StAddiEx  = 4'd10,
        StAddiWb  = 4'd11,
        StJEx     = 4'd12,
        StTrap    = 4'd13
    } state_e;

    // AluOpNone parks alu_control at zero in states that do not use the ALU.
    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10,
        AluOpNone  = 2'b11
    } aluop_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    function automatic logic is_mem_state(input state_e s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// ALU decoder: maps the controller's aluop plus the R-type funct field to an ALU control code
// and flags funct values the datapath does not implement.
module mips_alu_dec
    import mips_mc_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 3
) (
    input  aluop_e                aluop,
    input  logic [5:0]            funct,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  funct_illegal
);

    logic [2:0] code;

    always_comb begin
        code          = AluAnd;
        funct_illegal = 1'b0;
        unique case (aluop)
            AluOpAdd:   code = AluAdd;
            AluOpSub:   code = AluSub;
            AluOpFunct: begin
                case (funct)
                    FnAdd:   code = AluAdd;
                    FnSub:   code = AluSub;
                    FnAnd:   code = AluAnd;
                    FnOr:    code = AluOr;
                    FnSlt:   code = AluSlt;
                    default: funct_illegal = 1'b1;
                endcase
            end
            AluOpNone:  code = AluAnd;
            default:    code = AluAnd;
        endcase
    end

    assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main controller: Moore FSM with memory wait-state handshake, wait timeout
// and sticky illegal-instruction trap, driving the datapath and memory strobes.
module mips_mc_ctrl
    import mips_mc_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W  = 3,
    parameter bit          MEM_WAIT_EN = 1'b1,
    parameter int unsigned MAX_WAIT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal,
    output logic                  mem_timeout,
    output logic [3:0]            state_dbg
);

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;

    aluop_e aluop;
    logic   funct_illegal;
    logic   ready;
    logic   pc_write, branch;
    logic   mem_read_c, mem_write_c, ir_write_c, reg_write_c;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    mips_alu_dec #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_dec (
        .aluop         (aluop),
        .funct         (funct),
        .alu_control   (alu_control),
        .funct_illegal (funct_illegal)
    );

    // Kept apart from the next-state logic so funct_illegal never feeds back into its own cone.
    always_comb begin
        aluop = AluOpNone;
        case (state_q)
            StFetch, StDecode, StMemAdr, StAddiEx: aluop = AluOpAdd;
            StRtypeEx:                             aluop = AluOpFunct;
            StBeqEx, StBneEx:                      aluop = AluOpSub;
            default:                               aluop = AluOpNone;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        pc_write    = 1'b0;
        branch      = 1'b0;
        iord        = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write_c = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SrcBReg;
        pc_src      = PcSrcAlu;

        case (state_q)
            StFetch: begin
                mem_read_c = 1'b1;
                alu_src_b  = SrcBFour;
                if (ready) begin
                    ir_write_c = 1'b1;
                    pc_write   = 1'b1;
                    state_d    = StDecode;
                end
            end
            StDecode: begin
                alu_src_b = SrcBImmSh;
                case (op)
                    OpRtype:   state_d = StRtypeEx;
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:     state_d = StBeqEx;
                    OpBne:     state_d = StBneEx;
                    OpAddi:    state_d = StAddiEx;
                    OpJ:       state_d = StJEx;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = StTrap;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                state_d   = (op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                iord       = 1'b1;
                mem_read_c = 1'b1;
                if (ready) state_d = StMemWb;
            end
            StMemWb: begin
                mem_to_reg  = 1'b1;
                reg_write_c = 1'b1;
                state_d     = StFetch;
            end
            StMemWr: begin
                iord        = 1'b1;
                mem_write_c = 1'b1;
                if (ready) state_d = StFetch;
            end
            StRtypeEx: begin
                alu_src_a = 1'b1;
                if (funct_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = StTrap;
                end else begin
                    state_d = StAluWb;
                end
            end
            StAluWb: begin
                reg_dst     = 1'b1;
                reg_write_c = 1'b1;
                state_d     = StFetch;
            end
            StBeqEx, StBneEx: begin
                alu_src_a = 1'b1;
                pc_src    = PcSrcAluOut;
                branch    = (state_q == StBeqEx) ? zero : ~zero;
                state_d   = StFetch;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write_c = 1'b1;
                state_d     = StFetch;
            end
            StJEx: begin
                pc_src   = PcSrcJump;
                pc_write = 1'b1;
                state_d  = StFetch;
            end
            default: state_d = StTrap;
        endcase

        // Timeout fires on the wait cycle that would push the count past MaxWait.
        if (is_mem_state(state_q)) begin
            if (ready) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q == MaxWait) begin
                wait_cnt_d = '0;
                timeout_d  = 1'b1;
                state_d    = StTrap;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    assign pc_en       = ~reset & (pc_write | branch);
    assign mem_read    = ~reset & mem_read_c;
    assign mem_write   = ~reset & mem_write_c;
    assign ir_write    = ~reset & ir_write_c;
    assign reg_write   = ~reset & reg_write_c;
    assign illegal     = illegal_q;
    assign mem_timeout = timeout_q;
    assign state_dbg   = state_q;

endmodule
